seq_recognizer_ctrl: RTL

Controller for a programmable Mealy sequence recognizer. It accepts a pattern of up to K_MAX N-bit input symbols through a configuration handshake and arms recognition on a start command. While armed it drives the Mealy output z and counts matches. When a programmed match limit is reached it stops and holds a done/ack handshake. It sits between the control unit issuing recognition jobs and the x input stream.

---
 rtl/seq_recognizer_ctrl_if.sv | 31 +++
 rtl/seq_recognizer_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_recognizer_ctrl_if.sv
// Job/stream bundle between the recognition control unit and seq_recognizer_ctrl.
// The control unit drives the master side; the recognizer implements the slave side.
interface seq_recognizer_ctrl_if #(
    parameter int N     = 2,
    parameter int K_MAX = 4
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [2:0]           cfg_len;
    logic [N*K_MAX-1:0]   cfg_pattern;
    logic [7:0]           cfg_limit;
    logic                 cfg_err;
    logic                 start;
    logic                 abort;
    logic [N-1:0]         x;
    logic                 z;
    logic                 busy;
    logic                 done;
    logic                 ack;
    logic [7:0]           match_count;

    modport master (
        output cfg_valid, cfg_len, cfg_pattern, cfg_limit, start, abort, x, ack,
        input  cfg_ready, cfg_err, z, busy, done, match_count
    );

    modport slave (
        input  cfg_valid, cfg_len, cfg_pattern, cfg_limit, start, abort, x, ack,
        output cfg_ready, cfg_err, z, busy, done, match_count
    );
endinterface

// File: rtl/seq_recognizer_ctrl.sv
// Programmable Mealy sequence recognizer controller: loads a pattern, arms on start,
// drives z on every completed pattern and stops in DONE once the match limit is reached.
module seq_recognizer_ctrl #(
    parameter int N     = 2,
    parameter int K_MAX = 4
) (
    input  logic                 clock,
    input  logic                 reset_,
    seq_recognizer_ctrl_if.slave bus
);
    localparam int PW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    logic [PW-1:0]        p_r;
    logic [7:0]           count_r;
    logic                 cfg_ok_r;
    logic [N*K_MAX-1:0]   pat_r;
    logic [2:0]           len_r;
    logic [7:0]           limit_r;
    logic                 cfg_err_r;
    logic                 cfg_ready_r;
    logic                 busy_r;
    logic                 done_r;

    logic [N-1:0]         exp_sym_s;
    logic                 hit_s;
    logic                 last_s;
    logic                 first_hit_s;
    logic                 match_s;
    logic [PW-1:0]        p_next_s;
    logic [7:0]           count_inc_s;
    logic                 limit_hit_s;
    logic                 len_legal_s;

    // Progress/match evaluation for the current symbol; z is Mealy, so no register here
    always_comb begin
        exp_sym_s   = pat_r[N*p_r +: N];
        hit_s       = (bus.x == exp_sym_s);
        last_s      = ({1'b0, p_r} == (len_r - 3'd1));
        first_hit_s = (len_r > 3'd1) && (bus.x == pat_r[N-1:0]);
        match_s     = (state_r == ST_ARMED) && !bus.abort && hit_s && last_s;
        if (hit_s && !last_s) begin
            p_next_s = p_r + PW'(1);
        end else if (first_hit_s) begin
            p_next_s = PW'(1);
        end else begin
            p_next_s = '0;
        end
        if (count_r == 8'hFF) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + 8'd1;
        end
        // Compare on the unsaturated count so a limit of 255 is still reachable
        limit_hit_s = (limit_r != 8'd0) && (({1'b0, count_r} + 9'd1) >= {1'b0, limit_r});
        len_legal_s = (bus.cfg_len >= 3'd1) && (bus.cfg_len <= 3'(K_MAX));
    end

    assign bus.z           = match_s;
    assign bus.cfg_ready   = cfg_ready_r;
    assign bus.cfg_err     = cfg_err_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.match_count = count_r;

    // Controller FSM with config registers, match counter and registered status outputs
    always_ff @(posedge clock) begin
        if (reset_) begin
            state_r     <= ST_IDLE;
            p_r         <= '0;
            count_r     <= 8'd0;
            cfg_ok_r    <= 1'b0;
            pat_r       <= '0;
            len_r       <= 3'd0;
            limit_r     <= 8'd0;
            cfg_err_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.cfg_valid) begin
                        if (len_legal_s) begin
                            pat_r    <= bus.cfg_pattern;
                            len_r    <= bus.cfg_len;
                            limit_r  <= bus.cfg_limit;
                            cfg_ok_r <= 1'b1;
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end else if (bus.start && cfg_ok_r) begin
                        state_r     <= ST_ARMED;
                        p_r         <= '0;
                        count_r     <= 8'd0;
                        busy_r      <= 1'b1;
                        cfg_ready_r <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (bus.abort) begin
                        state_r     <= ST_IDLE;
                        p_r         <= '0;
                        busy_r      <= 1'b0;
                        cfg_ready_r <= 1'b1;
                    end else begin
                        p_r <= p_next_s;
                        if (match_s) begin
                            count_r <= count_inc_s;
                            if (limit_hit_s) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.abort || bus.ack) begin
                        state_r     <= ST_IDLE;
                        p_r         <= '0;
                        done_r      <= 1'b0;
                        cfg_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    p_r         <= '0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    cfg_ready_r <= 1'b1;
                end
            endcase
        end
    end
endmodule
